// File: rtl/laser_score.sv
// laser_score: buffers one image of NPTS points, then counts the points inside the union of two circles.
// Build option LASER_SCORE_OVERLAP_EN adds a second count (points inside both circles) on OVERLAP.
module laser_score #(
    parameter int NPTS      = 40,
    parameter int RADIUS_SQ = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PT_VALID,
    input  logic [3:0] X,
    input  logic [3:0] Y,
    input  logic       DONE_IN,
    input  logic [3:0] C1X,
    input  logic [3:0] C1Y,
    input  logic [3:0] C2X,
    input  logic [3:0] C2Y,
    output logic       BUSY,
    output logic [5:0] SCORE,
    output logic       SCORE_VALID,
    output logic [5:0] OVERLAP
);
    localparam int             CW   = $clog2(NPTS + 1);
    localparam logic [9:0]     R_SQ = 10'(RADIUS_SQ);

    // state    | meaning
    // S_IDLE   | one cycle after reset before loading starts
    // S_LOAD   | accepting point beats into the buffer
    // S_WAIT   | image complete, waiting for centres
    // S_EVAL   | one point per cycle, plus a final cycle to hand off the total
    // S_REPORT | SCORE/OVERLAP freshly updated, SCORE_VALID high
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_EVAL, S_REPORT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   load_cnt_q, load_cnt_d;
    logic [CW-1:0]   eval_cnt_q, eval_cnt_d;
    logic [5:0]      acc_q, acc_d;
    logic [5:0]      score_q, score_d;
    logic [3:0]      c1x_q, c1y_q, c2x_q, c2y_q;
    logic            cap_en, wr_en, eval_done;
    logic [3:0]      bx_mem [NPTS];
    logic [3:0]      by_mem [NPTS];
    logic [CW-1:0]   rd_idx;
    logic [3:0]      px, py;
    logic            in1, in2;

    function automatic logic [3:0] absdiff(input logic [3:0] a, input logic [3:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic inside_circ(input logic [3:0] pxi, input logic [3:0] pyi,
                                         input logic [3:0] cx, input logic [3:0] cy);
        logic [3:0] dx, dy;
        logic [8:0] d2;
        dx = absdiff(pxi, cx);
        dy = absdiff(pyi, cy);
        d2 = {5'd0, dx} * {5'd0, dx} + {5'd0, dy} * {5'd0, dy};
        return ({1'b0, d2} <= R_SQ);
    endfunction

    assign eval_done = (eval_cnt_q == CW'(NPTS));
    // The drain cycle (eval_cnt_q == NPTS) reads a harmless in-range entry.
    assign rd_idx    = eval_done ? '0 : eval_cnt_q;
    assign px        = bx_mem[rd_idx];
    assign py        = by_mem[rd_idx];
    assign in1       = inside_circ(px, py, c1x_q, c1y_q);
    assign in2       = inside_circ(px, py, c2x_q, c2y_q);

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        eval_cnt_d = eval_cnt_q;
        acc_d      = acc_q;
        score_d    = score_q;
        cap_en     = 1'b0;
        wr_en      = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d    = S_LOAD;
                load_cnt_d = '0;
            end
            S_LOAD: begin
                if (PT_VALID) begin
                    wr_en      = 1'b1;
                    load_cnt_d = load_cnt_q + 1'b1;
                    if (load_cnt_q == CW'(NPTS - 1)) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (DONE_IN) begin
                    cap_en     = 1'b1;
                    state_d    = S_EVAL;
                    eval_cnt_d = '0;
                    acc_d      = '0;
                end
            end
            S_EVAL: begin
                if (eval_done) begin
                    state_d = S_REPORT;
                    score_d = acc_q;
                end else begin
                    acc_d      = acc_q + {5'd0, (in1 | in2)};
                    eval_cnt_d = eval_cnt_q + 1'b1;
                end
            end
            S_REPORT: begin
                state_d    = S_LOAD;
                load_cnt_d = '0;
                eval_cnt_d = '0;
                acc_d      = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            load_cnt_q <= '0;
            eval_cnt_q <= '0;
            acc_q      <= '0;
            score_q    <= '0;
            c1x_q      <= '0;
            c1y_q      <= '0;
            c2x_q      <= '0;
            c2y_q      <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            eval_cnt_q <= eval_cnt_d;
            acc_q      <= acc_d;
            score_q    <= score_d;
            if (cap_en) begin
                c1x_q <= C1X;
                c1y_q <= C1Y;
                c2x_q <= C2X;
                c2y_q <= C2Y;
            end
        end
    end

    // Point buffer deliberately has no reset.
    always_ff @(posedge CLK) begin
        if (wr_en && !RST) begin
            bx_mem[load_cnt_q] <= X;
            by_mem[load_cnt_q] <= Y;
        end
    end

`ifdef LASER_SCORE_OVERLAP_EN
    logic [5:0] ov_acc_q, ov_acc_d, ov_q, ov_d;

    always_comb begin
        ov_acc_d = ov_acc_q;
        ov_d     = ov_q;
        case (state_q)
            S_WAIT:   if (DONE_IN) ov_acc_d = '0;
            S_EVAL: begin
                if (eval_done) ov_d = ov_acc_q;
                else           ov_acc_d = ov_acc_q + {5'd0, (in1 & in2)};
            end
            S_REPORT: ov_acc_d = '0;
            default:  ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ov_acc_q <= '0;
            ov_q     <= '0;
        end else begin
            ov_acc_q <= ov_acc_d;
            ov_q     <= ov_d;
        end
    end

    assign OVERLAP = ov_q;
`else
    assign OVERLAP = '0;
`endif

    assign SCORE       = score_q;
    assign SCORE_VALID = (state_q == S_REPORT);
    assign BUSY        = (state_q == S_EVAL) || (state_q == S_REPORT);
endmodule

// File: doc/laser_score.md
LASER_SCORE -- requirements
Module: laser_score

Interface
REQ-001 SHALL have parameter NPTS, default 40, number of points per image.
REQ-002 SHALL have parameter RADIUS_SQ, default 16, squared coverage radius (inclusive).
REQ-003 SHALL have the following ports:
- CLK  input  1  clock; one clock; reset is synchronous and active-high.
- RST  input  1  synchronous active-high reset.
- PT_VALID  input  1  point beat strobe.
- X  input  4  point column.
- Y  input  4  point row.
- DONE_IN  input  1  centres valid, driven by upstream circle search.
- C1X, C1Y, C2X, C2Y  input  4 each  circle centres.
- BUSY  output  1  high in EVAL and REPORT.
- SCORE  output  6  count of points inside the union of both circles.
- SCORE_VALID  output  1  one-cycle result strobe.
- OVERLAP  output  6  count of points inside both circles (LASER_SCORE_OVERLAP_EN only).

Function
REQ-004 SHALL implement states IDLE, LOAD, WAIT, EVAL, REPORT.
REQ-005 State transitions SHALL be:
- IDLE -> LOAD unconditionally.
- LOAD -> WAIT on the NPTS-th accepted beat.
- WAIT -> EVAL on the first cycle DONE_IN=1.
- EVAL -> REPORT after NPTS cycles.
- REPORT -> LOAD.
REQ-006 Loading:
- LOAD SHALL store X/Y into a NPTS-entry buffer at index load_cnt on each PT_VALID=1 edge.
- load_cnt SHALL increment by 1 per beat.
- In LOAD, DONE_IN SHALL be ignored, including on the same edge as the NPTS-th beat.
REQ-007 PT_VALID beats in WAIT, EVAL or REPORT SHALL be ignored; the buffer SHALL be unchanged.
REQ-008 The WAIT->EVAL edge SHALL capture C1X/C1Y/C2X/C2Y into internal registers; later centre changes SHALL NOT affect the result.
REQ-009 Evaluation arithmetic:
- EVAL SHALL test one buffered point per cycle, index 0..NPTS-1.
- dx=|px-cx| and dy=|py-cy| SHALL be 4-bit unsigned.
- d2=dx*dx+dy*dy SHALL be 9-bit unsigned.
- A point is inside a circle iff d2 <= RADIUS_SQ.
REQ-010 The score accumulator SHALL increment when the point is inside C1 or inside C2; a point inside both SHALL count once.
REQ-011 SCORE SHALL update and SCORE_VALID SHALL be 1 for exactly the REPORT cycle, i.e. the cycle after edge k+NPTS+1 where edge k sampled DONE_IN=1 in WAIT.
REQ-012 SCORE SHALL hold its value until the next REPORT.
REQ-013 On REPORT exit, load_cnt and the accumulators SHALL clear so that the next image loads from index 0.
REQ-014 BUSY SHALL be 1 exactly in EVAL and REPORT.

Reset
REQ-015 RST=1 sampled at any edge, in any state, SHALL force IDLE and set SCORE=0, OVERLAP=0, SCORE_VALID=0, BUSY=0, load_cnt=0.
REQ-016 Buffer contents SHALL NOT be reset.
REQ-017 RST during EVAL SHALL abort evaluation; no SCORE_VALID SHALL follow.
REQ-018 The first accepted beat after reset SHALL be the first PT_VALID=1 edge in LOAD, i.e. at least two edges after RST deasserts.

Configuration
REQ-019 Macro LASER_SCORE_OVERLAP_EN:
- Defined: a second accumulator SHALL count points inside both circles, and OVERLAP SHALL update in REPORT alongside SCORE.
- Undefined: OVERLAP SHALL be tied to 0 and no second accumulator SHALL exist.
- SCORE behaviour SHALL be identical either way.

Verification
REQ-020 40 points all (8,8); C1=(8,8), C2=(0,0) -> SCORE=40, SCORE_VALID one cycle, 41 cycles after DONE_IN sampled.
REQ-021 40 points all (0,15); C1=(4,15), C2=(15,0) -> SCORE=40 (d2=16 boundary inclusive). C1=(5,15) -> SCORE=0.
REQ-022 20 points (3,3) and 20 points (12,12):
- C1=(3,3), C2=(12,12) -> SCORE=40, OVERLAP=0.
- C1=C2=(3,3) -> SCORE=20, OVERLAP=20 (macro defined) or 0 (undefined).
REQ-023 45 PT_VALID beats, DONE_IN=1 throughout LOAD -> beats 41-45 ignored; capture on first WAIT cycle; SCORE equals the result for the first 40 points.
REQ-024 RST pulsed at EVAL cycle 20 -> BUSY=0 next cycle, no SCORE_VALID, SCORE=0. A fresh 40-point image then scores correctly.
REQ-025 Centres changed during EVAL -> SCORE reflects the centres captured at the DONE_IN edge.
